// File: rtl/multicycle_control.sv
// Main control FSM for a multicycle RV32 subset (R, I-ALU, LW, SW, BEQ).
// Every output is a function of the current state and the live inputs.
// While rst_n is low, all outputs are forced to zero.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FETCH    | read the instruction at PC, PC+4 -> PC when memory is ready
// DECODE   | read registers, compute the branch target (old PC + imm)
// MEMADR   | effective address = rs1 + imm
// MEMREAD  | load access, held until mem_ready
// MEMWB    | write the load data to rd
// MEMWRITE | store access, held until mem_ready, then retire
// EXEC_R   | rs1 op rs2
// EXEC_I   | rs1 op imm, with funct7 forced to zero in the ALU decode
// ALUWB    | write the ALU result to rd
// BRANCH   | compare rs1 with rs2, take the BEQ branch on zero
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       f7_zero,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  state_t state_q, state_d;

  // state register, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // next-state and control decode; reset forces every output low
  always_comb begin
    state_d    = S_FETCH;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    f7_zero    = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        state_d    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BR:        state_d = S_BRANCH;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        // Only loads and stores reach this state; any other opcode falls back to FETCH.
        if (opcode == OP_LW)      state_d = S_MEMREAD;
        else if (opcode == OP_SW) state_d = S_MEMWRITE;
        else                      state_d = S_FETCH;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req    = 1'b1;
        mem_write  = 1'b1;
        adr_src    = 1'b1;
        instr_done = mem_ready;
        state_d    = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        f7_zero   = 1'b1;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        instr_done = 1'b1;
        // Only BEQ is supported; any other branch funct3 retires as a no-op.
        pc_write   = zero && (funct3 == 3'b000);
      end
      default: state_d = S_FETCH;
    endcase
    if (!rst_n) begin
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      f7_zero    = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

  // debug view of the state, zero while reset is asserted
  assign state = rst_n ? state_q : 4'd0;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class
// cycle by cycle and compares the state and packed control word against
// hand-written expectations.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic       f7_zero, instr_done, illegal;
  logic [3:0] state;

  int vectors = 0;
  int miscompares = 0;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .f7_zero(f7_zero),
    .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // packed control word:
  // {mem_req,mem_write,adr_src,ir_write,pc_write,reg_write,result_src,a,b,alu_op,f7_zero,instr_done,illegal}
  logic [16:0] ctl_vec;
  assign ctl_vec = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                    result_src, alu_src_a, alu_src_b, alu_op, f7_zero, instr_done, illegal};

  function automatic logic [16:0] ev(
    input logic mr, input logic mw, input logic ad, input logic irw,
    input logic pcw, input logic rw, input logic [1:0] rs, input logic [1:0] a,
    input logic [1:0] b, input logic [1:0] op, input logic f7, input logic dn,
    input logic il);
    return {mr, mw, ad, irw, pcw, rw, rs, a, b, op, f7, dn, il};
  endfunction

  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // check the current cycle, then advance to 1 ns after the next rising edge
  task automatic cyc(input string tag, input logic [3:0] es, input logic [16:0] ec);
    #1;
    chk({tag, ".state"}, {13'd0, state}, {13'd0, es});
    chk({tag, ".ctl"}, ctl_vec, ec);
    @(posedge clk);
    #1;
  endtask

  logic [16:0] e_fetch, e_fetch_stall, e_decode, e_memadr, e_memread, e_memwb;
  logic [16:0] e_exec_r, e_exec_i, e_aluwb, e_none;

  initial begin
    e_fetch       = ev(1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,2'b10,2'b00,2'b10,2'b00,1'b0,1'b0,1'b0);
    e_fetch_stall = ev(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,2'b00,1'b0,1'b0,1'b0);
    e_decode      = ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,2'b00,1'b0,1'b0,1'b0);
    e_memadr      = ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b00,1'b0,1'b0,1'b0);
    e_memread     = ev(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0);
    e_memwb       = ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b00,2'b00,2'b00,1'b0,1'b1,1'b0);
    e_exec_r      = ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b10,1'b0,1'b0,1'b0);
    e_exec_i      = ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b10,1'b1,1'b0,1'b0);
    e_aluwb       = ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0,1'b1,1'b0);
    e_none        = 17'd0;

    rst_n = 1'b0; opcode = 7'b0110011; funct3 = 3'b000; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    // reset held: FETCH would drive mem_req, but reset masks everything
    cyc("reset", 4'd0, e_none);

    // R-type, mem_ready high: 0,1,6,8,0
    rst_n = 1'b1;
    cyc("r.fetch", 4'd0, e_fetch);
    cyc("r.decode", 4'd1, e_decode);
    cyc("r.exec", 4'd6, e_exec_r);
    cyc("r.aluwb", 4'd8, e_aluwb);

    // LW with three stall cycles in MEMREAD; stalled fetch first
    opcode = 7'b0000011; mem_ready = 1'b0;
    cyc("lw.fstall", 4'd0, e_fetch_stall);
    mem_ready = 1'b1;
    cyc("lw.fetch", 4'd0, e_fetch);
    mem_ready = 1'b0;                      // ignored outside memory states
    cyc("lw.decode", 4'd1, e_decode);
    cyc("lw.memadr", 4'd2, e_memadr);
    cyc("lw.rd0", 4'd3, e_memread);
    cyc("lw.rd1", 4'd3, e_memread);
    cyc("lw.rd2", 4'd3, e_memread);
    mem_ready = 1'b1;
    cyc("lw.rd3", 4'd3, e_memread);
    cyc("lw.memwb", 4'd4, e_memwb);

    // BEQ taken
    opcode = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
    cyc("beq1.fetch", 4'd0, e_fetch);
    cyc("beq1.decode", 4'd1, e_decode);
    cyc("beq1.branch", 4'd9, ev(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b10,2'b00,2'b01,1'b0,1'b1,1'b0));
    // BEQ not taken
    zero = 1'b0;
    cyc("beq0.fetch", 4'd0, e_fetch);
    cyc("beq0.decode", 4'd1, e_decode);
    cyc("beq0.branch", 4'd9, ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b01,1'b0,1'b1,1'b0));
    // unsupported branch funct3 with zero set: no pc_write
    funct3 = 3'b001; zero = 1'b1;
    cyc("bne.fetch", 4'd0, e_fetch);
    cyc("bne.decode", 4'd1, e_decode);
    cyc("bne.branch", 4'd9, ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b01,1'b0,1'b1,1'b0));

    // I-ALU
    opcode = 7'b0010011; funct3 = 3'b000; zero = 1'b0;
    cyc("i.fetch", 4'd0, e_fetch);
    cyc("i.decode", 4'd1, e_decode);
    cyc("i.exec", 4'd7, e_exec_i);
    cyc("i.aluwb", 4'd8, e_aluwb);

    // illegal opcode: two cycles, no reg_write
    opcode = 7'b1111111;
    cyc("ill.fetch", 4'd0, e_fetch);
    cyc("ill.decode", 4'd1, ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,2'b00,1'b0,1'b0,1'b1));

    // SW completing immediately
    opcode = 7'b0100011;
    cyc("sw.fetch", 4'd0, e_fetch);
    cyc("sw.decode", 4'd1, e_decode);
    cyc("sw.memadr", 4'd2, e_memadr);
    cyc("sw.write", 4'd5, ev(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b1,1'b0));

    // SW stalled, then reset in the middle of the stall
    cyc("sws.fetch", 4'd0, e_fetch);
    cyc("sws.decode", 4'd1, e_decode);
    mem_ready = 1'b0;
    cyc("sws.memadr", 4'd2, e_memadr);
    cyc("sws.w0", 4'd5, ev(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0));
    cyc("sws.w1", 4'd5, ev(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0));
    rst_n = 1'b0;
    cyc("sws.rst0", 4'd0, e_none);
    cyc("sws.rst1", 4'd0, e_none);
    rst_n = 1'b1;
    cyc("sws.after", 4'd0, e_fetch_stall);
    mem_ready = 1'b1;
    opcode = 7'b0110011;
    cyc("post.fetch", 4'd0, e_fetch);
    cyc("post.decode", 4'd1, e_decode);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  synchronous active-low reset; all state changes on rising clk edge only.
REQ-002 SHALL have inputs: opcode  in  7  IR[6:0]; funct3  in  3  IR[14:12]; zero  in  1  ALU zero flag; mem_ready  in  1  memory access completes this cycle.
REQ-003 SHALL have outputs: mem_req  out  1; mem_write  out  1; adr_src  out  1  (0 PC, 1 ALU-out reg); ir_write  out  1; pc_write  out  1.
REQ-004 SHALL have outputs: reg_write  out  1; result_src  out  2  (00 ALU-out reg, 01 mem data, 10 ALU result); alu_src_a  out  2  (00 PC, 01 old PC, 10 rs1); alu_src_b  out  2  (00 rs2, 01 imm, 10 const 4).
REQ-005 SHALL have outputs: alu_op  out  2  (00 add, 01 sub, 10 funct-decoded, 11 unused); f7_zero  out  1  (datapath forces funct7=0 into ALU-control decode); instr_done  out  1  retire pulse; illegal  out  1  illegal-opcode pulse; state  out  4  debug.

Function
REQ-006 SHALL implement FSM states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9; codes 10-15 unreachable, SHALL go to FETCH.
REQ-007 SHALL decode opcodes: 0110011 R, 0010011 I-ALU, 0000011 LW, 0100011 SW, 1100011 BEQ; all others illegal.
REQ-008 Every output not listed for a state SHALL be 0; outputs are functions of state plus mem_ready/opcode/funct3/zero only.
REQ-009 FETCH: mem_req=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10; ir_write=pc_write=mem_ready; stay while mem_ready=0, else DECODE.
REQ-010 DECODE: a=01, b=01, alu_op=00 (branch target); next R->EXEC_R, I-ALU->EXEC_I, LW/SW->MEMADR, BEQ->BRANCH, illegal->FETCH with illegal=1 for that cycle.
REQ-011 MEMADR: a=10, b=01, alu_op=00; LW->MEMREAD, SW->MEMWRITE.
REQ-012 MEMREAD: mem_req=1, adr_src=1; stay while mem_ready=0, else MEMWB.
REQ-013 MEMWB: result_src=01, reg_write=1, instr_done=1; ->FETCH.
REQ-014 MEMWRITE: mem_req=1, mem_write=1, adr_src=1; stay while mem_ready=0; on mem_ready=1 instr_done=1, ->FETCH.
REQ-015 EXEC_R: a=10, b=00, alu_op=10; ->ALUWB. EXEC_I: a=10, b=01, alu_op=10, f7_zero=1; ->ALUWB.
REQ-016 ALUWB: result_src=00, reg_write=1, instr_done=1; ->FETCH.
REQ-017 BRANCH: a=10, b=00, alu_op=01, result_src=00, instr_done=1; pc_write = zero AND (funct3==000); funct3!=000 SHALL be no-op (no pc_write); ->FETCH.
REQ-018 mem_req SHALL stay asserted with stable adr_src/mem_write for every cycle of a stalled access; mem_ready outside FETCH/MEMREAD/MEMWRITE SHALL be ignored.
REQ-019 ir_write, pc_write, reg_write SHALL each be high at most one cycle per instruction (pc_write at most twice for taken BEQ: FETCH and BRANCH).
REQ-020 With mem_ready tied 1, latency SHALL be: R/I 4 cycles, LW 5, SW 4, BEQ 3, illegal 2 (FETCH to next FETCH).

Reset
REQ-021 rst_n=0 sampled at a rising edge SHALL set state=FETCH; while rst_n=0 all outputs SHALL be 0 (overrides REQ-009), state output = 0.
REQ-022 Reset mid-instruction (including a stalled MEMWRITE) SHALL abandon it with no further reg_write/mem_write/pc_write; first cycle after rst_n=1 is FETCH.

Verification
REQ-023 mem_ready=1, opcode=0110011 -> states 0,1,6,8,0; alu_op=10 in state 6; reg_write and instr_done high only in state 8.
REQ-024 opcode=0000011, mem_ready low 3 cycles in MEMREAD -> state 3 held 4 cycles, mem_req=1, adr_src=1 stable; then MEMWB with result_src=01, reg_write=1.
REQ-025 opcode=1100011, funct3=000: zero=1 -> pc_write=1 in BRANCH, alu_op=01; zero=0 -> pc_write=0; funct3=001, zero=1 -> pc_write=0.
REQ-026 opcode=0010011 -> EXEC_I with f7_zero=1, alu_src_b=01; opcode=1111111 -> illegal=1 in DECODE, next FETCH, no reg_write.
REQ-027 rst_n=0 during stalled MEMWRITE -> next cycle all outputs 0, mem_write=0; after rst_n=1 state=0 with mem_req=1.
